rr_decode_arbiter: RTL and testbench

- Four-requester round-robin arbiter for one shared resource.
- Output is a one-hot grant vector built from a 2-bit winner index, the same form as the 2-to-4 decoder with enable.
- Sits between requesting masters and the shared resource's select/enable lines.
- Grants are held until released, with a programmable maximum hold time that forces release.

---
 rtl/rr_decode_arbiter.sv | 113 +++++++++++
 tb/tb_rr_decode_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// Four-requester round-robin arbiter with one-hot decoded grant output.
// A grant is held until its owner pulses done, drops its request, or has
// held it for MAX_HOLD cycles (forced release, flagged by a timeout pulse).
// On release the next winner is chosen in the same cycle, so back-to-back
// grants have no idle gap.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [1:0]       ptr, ptr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       idx_n;
    logic             vld_n;
    logic             timeout_n;
    logic [3:0]       gnt_n;

    logic             own_done;
    logic             own_drop;
    logic             at_max;
    logic             release_now;
    logic [1:0]       ptr_after;

    // First set request bit scanning p, p+1, p+2, p+3 (mod 4).
    // Walking offsets from highest to lowest lets the closest hit win.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] c;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            c = p + 2'(i);
            if (r[c]) pick = c;
        end
    endfunction

    assign own_done    = done[gnt_idx];
    assign own_drop    = ~req[gnt_idx];
    assign at_max      = (cnt == CNT_W'(MAX_HOLD));
    assign release_now = own_done | own_drop | at_max;
    assign ptr_after   = gnt_idx + 2'd1;

    // Next-state, pointer, hold counter and registered-output values.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        idx_n     = gnt_idx;
        vld_n     = gnt_vld;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n = GRANT;
                    idx_n   = pick(req, ptr);
                    vld_n   = 1'b1;
                    cnt_n   = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_n     = ptr_after;
                    // Forced release only when nothing else ended the grant.
                    timeout_n = at_max & ~own_done & ~own_drop;
                    if (|req) begin
                        idx_n = pick(req, ptr_after);
                        cnt_n = CNT_W'(1);
                    end else begin
                        state_n = IDLE;
                        vld_n   = 1'b0;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        gnt_n = vld_n ? (4'b0001 << idx_n) : 4'b0000;
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            gnt_idx <= 2'd0;
            gnt_vld <= 1'b0;
            gnt     <= 4'b0000;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt_idx <= idx_n;
            gnt_vld <= vld_n;
            gnt     <= gnt_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed bench for rr_decode_arbiter: a cycle-by-cycle vector table for
// the MAX_HOLD=8 instance plus hand sequences for reset and MAX_HOLD=1.
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt, gnt1;
    logic [1:0] gnt_idx, gnt_idx1;
    logic       gnt_vld, gnt_vld1;
    logic       timeout, timeout1;

    int checks = 0;
    int errors = 0;

    rr_decode_arbiter #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
    );

    rr_decode_arbiter #(.MAX_HOLD(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt1), .gnt_idx(gnt_idx1), .gnt_vld(gnt_vld1), .timeout(timeout1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] r, input logic [3:0] d, input logic [3:0] g,
                       input logic [1:0] ix, input logic v, input logic t);
        vec_t e;
        e.req = r; e.done = d; e.gnt = g; e.idx = ix; e.vld = v; e.to = t;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
    task automatic step(input logic [3:0] r, input logic [3:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] m1_gnt[6];
    logic       m1_to[6];

    initial begin
        req   = 4'b0000;
        done  = 4'b0000;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_idx", {2'b00, gnt_idx}, 4'd0);
        chk("rst_vld", {3'b000, gnt_vld}, 4'd0);
        chk("rst_to", {3'b000, timeout}, 4'd0);

        // Full contention from ptr=0: order 0,1,2,3,0, done after 2 cycles each.
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b1111, 4'b0001, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0);
        add(4'b1111, 4'b0010, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b1111, 4'b0100, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b1111, 4'b1000, 4'b0001, 2'd0, 1, 0);
        // Non-owner done is ignored.
        add(4'b1111, 4'b1000, 4'b0001, 2'd0, 1, 0);
        add(4'b0000, 4'b0001, 4'b0000, 2'd0, 0, 0);   // ptr -> 1
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Single request, done releases to idle; ptr becomes 3.
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
        add(4'b0000, 4'b0100, 4'b0000, 2'd0, 0, 0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0);   // ptr=3 picks 3 over 0
        add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);   // owner 3 drops, ptr wraps to 0
        add(4'b1001, 4'b0000, 4'b0001, 2'd0, 1, 0);   // requester 0 wins, hold cycle 1
        for (int k = 2; k <= 8; k++)
            add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 1);   // forced release after 8 cycles
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0);
        // Owner 1 done hands to 0; 0 holds to cnt==8 then done coincides with it.
        add(4'b0001, 4'b0010, 4'b0001, 2'd0, 1, 0);
        for (int k = 2; k <= 8; k++)
            add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
        add(4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 0);   // normal release, sole requester re-granted
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);   // ptr -> 1

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vq[i]) begin
            step(vq[i].req, vq[i].done);
            chk($sformatf("v%0d_gnt", i), gnt, vq[i].gnt);
            chk($sformatf("v%0d_vld", i), {3'b000, gnt_vld}, {3'b000, vq[i].vld});
            chk($sformatf("v%0d_to", i), {3'b000, timeout}, {3'b000, vq[i].to});
            if (vq[i].vld)
                chk($sformatf("v%0d_idx", i), {2'b00, gnt_idx}, {2'b00, vq[i].idx});
        end

        // Reset in the middle of a grant to requester 2 (ptr is 1 here).
        step(4'b0100, 4'b0000);
        chk("pre_rst_gnt", gnt, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 4'b0000);
        chk("async_rst_vld", {3'b000, gnt_vld}, 4'd0);
        chk("async_rst_to", {3'b000, timeout}, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0110, 4'b0000);
        chk("post_rst_gnt", gnt, 4'b0010);
        chk("post_rst_idx", {2'b00, gnt_idx}, 4'd1);

        // MAX_HOLD=1 instance: rotation every cycle with timeout pulses.
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        m1_gnt[0] = 4'b0001; m1_to[0] = 1'b0;
        m1_gnt[1] = 4'b0010; m1_to[1] = 1'b1;
        m1_gnt[2] = 4'b0100; m1_to[2] = 1'b1;
        m1_gnt[3] = 4'b1000; m1_to[3] = 1'b1;
        m1_gnt[4] = 4'b0001; m1_to[4] = 1'b1;
        m1_gnt[5] = 4'b0010; m1_to[5] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(4'b1111, (k == 5) ? 4'b0001 : 4'b0000);
            chk($sformatf("mh1_%0d_gnt", k), gnt1, m1_gnt[k]);
            chk($sformatf("mh1_%0d_to", k), {3'b000, timeout1}, {3'b000, m1_to[k]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
